// File: rtl/muldiv_seq.sv
// Sequential signed multiply/divide: radix-2 Booth multiply, non-restoring divide on magnitudes.
// One iteration per cycle, 33-cycle latency from start to done, result in HI:LO layout.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 op,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t            state;
    logic [CW-1:0]     count;

    logic              op_q;
    logic              sign_a;
    logic              sign_b;
    logic              b_zero;
    logic [WIDTH-1:0]  a_q;

    // Booth product register {acc, mplr, qm1}; acc is one bit wider than the operand
    logic [WIDTH:0]    mcand;
    logic [WIDTH:0]    acc;
    logic [WIDTH-1:0]  mplr;
    logic              qm1;

    // Two guard bits keep the shifted partial remainder in range for a 2^(W-1) divisor
    logic [WIDTH+1:0]  rem;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH:0]    dvsr;

    logic [WIDTH:0]    booth_sum;
    logic [WIDTH+1:0]  rem_shift;
    logic [WIDTH+1:0]  rem_next;
    logic [WIDTH-1:0]  rem_fix;
    logic [WIDTH-1:0]  quo_signed;
    logic [WIDTH-1:0]  rem_signed;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH:0]    b_mag;

    always_comb begin
        booth_sum = acc;
        case ({mplr[0], qm1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase

        rem_shift = {rem[WIDTH:0], quo[WIDTH-1]};
        if (rem[WIDTH+1])
            rem_next = rem_shift + {1'b0, dvsr};
        else
            rem_next = rem_shift - {1'b0, dvsr};

        // Only the low bits of the restored remainder matter; it is below the divisor
        if (rem[WIDTH+1])
            rem_fix = rem[WIDTH-1:0] + dvsr[WIDTH-1:0];
        else
            rem_fix = rem[WIDTH-1:0];

        quo_signed = (sign_a ^ sign_b) ? -quo : quo;
        rem_signed = sign_a ? -rem_fix : rem_fix;

        a_mag = a_in[WIDTH-1] ? -a_in : a_in;
        b_mag = {1'b0, (b_in[WIDTH-1] ? -b_in : b_in)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_q    <= a_in;
                        sign_a <= a_in[WIDTH-1];
                        sign_b <= b_in[WIDTH-1];
                        b_zero <= (b_in == '0);
                        mcand  <= {a_in[WIDTH-1], a_in};
                        acc    <= '0;
                        mplr   <= b_in;
                        qm1    <= 1'b0;
                        rem    <= '0;
                        quo    <= a_mag;
                        dvsr   <= b_mag;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    if (op_q) begin
                        rem <= rem_next;
                        quo <= {quo[WIDTH-2:0], ~rem_next[WIDTH+1]};
                    end else begin
                        acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        mplr <= {booth_sum[0], mplr[WIDTH-1:1]};
                        qm1  <= mplr[0];
                    end
                    count <= count + 1'b1;
                    if (count == LAST_ITER)
                        state <= FIX;
                end

                FIX: begin
                    if (!op_q) begin
                        result   <= {acc[WIDTH-1:0], mplr};
                        div_zero <= 1'b0;
                    end else if (b_zero) begin
                        result   <= {a_q, {WIDTH{1'b1}}};
                        div_zero <= 1'b1;
                    end else begin
                        result   <= {rem_signed, quo_signed};
                        div_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized bench for muldiv_seq; expected results come from plain
// 64-bit signed arithmetic rather than from any iterative algorithm.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void refModel(input logic opv, input logic [31:0] a, input logic [31:0] b,
                                     output logic [63:0] res, output logic dz);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!opv) begin
            res = 64'(sa * sb);
            dz  = 1'b0;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
            dz  = 1'b1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
            dz  = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds start for one rising edge, then scrambles the operand bus
    task automatic applyStimulus(input logic opv, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = opv;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        op    = 1'($urandom_range(0, 1));
    endtask

    task automatic waitDone(input int already, output int cycles);
        cycles = already;
        while (done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic checkCompletion(input string tag, input int cycles, input logic opv,
                                   input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp_res;
        logic        exp_dz;
        refModel(opv, a, b, exp_res, exp_dz);
        checkOutput($sformatf("%s latency", tag), 64'(cycles), 64'd33);
        checkOutput($sformatf("%s result", tag), result, exp_res);
        checkOutput($sformatf("%s div_zero", tag), 64'(div_zero), 64'(exp_dz));
        checkOutput($sformatf("%s busy at done", tag), 64'(busy), 64'd0);
    endtask

    task automatic runOp(input string tag, input logic opv, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        applyStimulus(opv, a, b);
        checkOutput($sformatf("%s busy after start", tag), 64'(busy), 64'd1);
        waitDone(0, cycles);
        checkCompletion(tag, cycles, opv, a, b);
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s done pulse width", tag), 64'(done), 64'd0);
    endtask

    initial begin
        int          cycles;
        logic        saw_done;
        logic        rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset result", result, 64'd0);
        checkOutput("reset div_zero", 64'(div_zero), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        runOp("mul 7*-3", 1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
        checkOutput("mul 7*-3 literal", result, 64'hFFFF_FFFF_FFFF_FFEB);
        runOp("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000);
        checkOutput("mul min*min literal", result, 64'h4000_0000_0000_0000);
        runOp("mul max*max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        checkOutput("mul max*max literal", result, 64'h3FFF_FFFF_0000_0001);
        runOp("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        checkOutput("div -7/2 literal", result, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9);
        checkOutput("div 100/-7 literal", result, 64'h0000_0002_FFFF_FFF2);
        runOp("div 100/0", 1'b1, 32'd100, 32'd0);
        checkOutput("div 100/0 literal", result, 64'h0000_0064_FFFF_FFFF);
        runOp("mul 1*1", 1'b0, 32'd1, 32'd1);
        runOp("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div min/-1 literal", result, 64'h0000_0000_8000_0000);

        // Second start while busy must be ignored
        applyStimulus(1'b0, 32'd12345, 32'hFFFF_FF00);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = 1'b1;
        a_in  = 32'd99;
        b_in  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(5, cycles);
        checkCompletion("overlap", cycles, 1'b0, 32'd12345, 32'hFFFF_FF00);

        // Start on the done cycle is accepted
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'd77);
        checkOutput("b2b done drops", 64'(done), 64'd0);
        checkOutput("b2b busy", 64'(busy), 64'd1);
        waitDone(0, cycles);
        checkCompletion("b2b", cycles, 1'b1, 32'hDEAD_BEEF, 32'd77);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation
        applyStimulus(1'b0, 32'd3, 32'd5);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset result", result, 64'd0);
        checkOutput("midreset done", 64'(done), 64'd0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1)
                saw_done = 1'b1;
        end
        checkOutput("midreset no done", 64'(saw_done), 64'd0);
        runOp("after reset", 1'b0, 32'hFFFF_FFF0, 32'd1000);

        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(0, 15)) - 32'd8;
                2: ra = 32'($urandom_range(0, 255)) - 32'd128;
                default: ;
            endcase
            runOp($sformatf("rand%0d", i), rop, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
